// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if
// Bundles everything between the arbiter, its three requesters (VGA reader,
// decompressor, UART writer) and the SRAM controller.
//   slave  modport : the arbiter's view (requests in, grants/SRAM port out)
//   master modport : the requesters' and SRAM controller's view
// Clock and Reset are not part of the bundle; they stay plain ports.
interface sram_access_arbiter_if;
    // VGA requester (read only)
    logic        Req_vga;
    logic [17:0] Addr_vga;
    // Decompressor requester (read or write, optional burst lock)
    logic        Req_dec;
    logic        We_n_dec;
    logic [17:0] Addr_dec;
    logic [15:0] Wdata_dec;
    logic        Lock_dec;
    // UART requester (write only)
    logic        Req_uart;
    logic [17:0] Addr_uart;
    logic [15:0] Wdata_uart;
    // Same-cycle grants
    logic        Gnt_vga;
    logic        Gnt_dec;
    logic        Gnt_uart;
    // SRAM controller side
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    // Read return
    logic [15:0] Rdata;
    logic        Rvalid_vga;
    logic        Rvalid_dec;

    modport slave (
        input  Req_vga, Addr_vga,
        input  Req_dec, We_n_dec, Addr_dec, Wdata_dec, Lock_dec,
        input  Req_uart, Addr_uart, Wdata_uart,
        input  SRAM_read_data,
        output Gnt_vga, Gnt_dec, Gnt_uart,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output Rdata, Rvalid_vga, Rvalid_dec
    );

    modport master (
        output Req_vga, Addr_vga,
        output Req_dec, We_n_dec, Addr_dec, Wdata_dec, Lock_dec,
        output Req_uart, Addr_uart, Wdata_uart,
        output SRAM_read_data,
        input  Gnt_vga, Gnt_dec, Gnt_uart,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  Rdata, Rvalid_vga, Rvalid_dec
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares one SRAM port between a VGA reader, a decompressor and a UART writer.
// VGA has priority; a saturating starvation counter forces one non-VGA slot
// after STARVE_LIMIT consecutive VGA wins while others wait. Decompressor and
// UART alternate round-robin, except that a locked decompressor burst keeps
// the non-VGA slot. Grants are combinational; the winner's address/data/we_n
// are registered onto the SRAM port at the next edge. Each read is tracked
// through a tagged shift register so Rvalid_x lines up with SRAM_read_data.
// Ports:
//   Clock  : single rising-edge clock
//   Reset  : asynchronous active-high reset
//   bus    : sram_access_arbiter_if.slave (requests, grants, SRAM port, Rdata)
module sram_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    sram_access_arbiter_if.slave   bus
);
    localparam int CW    = $clog2(STARVE_LIMIT + 1);
    localparam int DEPTH = READ_LATENCY + 1;

    localparam logic [0:0] PTR_DEC  = 1'b0;
    localparam logic [0:0] PTR_UART = 1'b1;
    localparam logic [0:0] TAG_VGA  = 1'b0;
    localparam logic [0:0] TAG_DEC  = 1'b1;

    logic [CW-1:0]    starve_q, starve_d;
    logic [0:0]       ptr_q, ptr_d;
    logic             last_dec_q, last_dec_d;
    logic [17:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             we_n_q, we_n_d;
    logic [DEPTH-1:0] pv_q, pv_d;
    logic [DEPTH-1:0] ptag_q, ptag_d;

    logic             nv_req;
    logic             starve_hit;
    logic             pick_dec;
    logic             gnt_vga, gnt_dec, gnt_uart;
    logic             push_v;
    logic [0:0]       push_tag;

    // Arbitration
    always_comb begin
        nv_req     = bus.Req_dec | bus.Req_uart;
        starve_hit = (starve_q == CW'(STARVE_LIMIT));

        // Choice among the non-VGA requesters. A lock only matters when both
        // are contending and the decompressor held the previous non-VGA slot.
        pick_dec = bus.Req_dec;
        if (bus.Req_dec && bus.Req_uart) begin
            if (bus.Lock_dec && last_dec_q)
                pick_dec = 1'b1;
            else
                pick_dec = (ptr_q == PTR_DEC);
        end

        // Grants are masked while Reset is high because they are combinational.
        gnt_vga  = ~Reset & bus.Req_vga & ~(starve_hit & nv_req);
        gnt_dec  = ~Reset & ~gnt_vga & bus.Req_dec & pick_dec;
        gnt_uart = ~Reset & ~gnt_vga & bus.Req_uart & ~pick_dec;
    end

    // Next-state logic
    always_comb begin
        starve_d   = starve_q;
        ptr_d      = ptr_q;
        last_dec_d = last_dec_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_n_d     = 1'b1;
        push_v     = 1'b0;
        push_tag   = TAG_VGA;

        if (gnt_dec || gnt_uart || !nv_req)
            starve_d = '0;
        else if (gnt_vga && !starve_hit)
            starve_d = starve_q + CW'(1);

        if (gnt_vga) begin
            addr_d   = bus.Addr_vga;
            push_v   = 1'b1;
            push_tag = TAG_VGA;
        end
        if (gnt_dec) begin
            addr_d     = bus.Addr_dec;
            wdata_d    = bus.Wdata_dec;
            we_n_d     = bus.We_n_dec;
            ptr_d      = PTR_UART;
            last_dec_d = 1'b1;
            push_v     = bus.We_n_dec;
            push_tag   = TAG_DEC;
        end
        if (gnt_uart) begin
            addr_d     = bus.Addr_uart;
            wdata_d    = bus.Wdata_uart;
            we_n_d     = 1'b0;
            ptr_d      = PTR_DEC;
            last_dec_d = 1'b0;
        end
    end

    // Read-tracking shift register: stage 0 loads the new read, each later
    // stage takes its predecessor, the last stage drives Rvalid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign pv_d[gi]   = push_v;
                assign ptag_d[gi] = push_tag[0];
            end else begin : g_body
                assign pv_d[gi]   = pv_q[gi-1];
                assign ptag_d[gi] = ptag_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starve_q   <= '0;
            ptr_q      <= PTR_DEC;
            last_dec_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_n_q     <= 1'b1;
            pv_q       <= '0;
            ptag_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            ptr_q      <= ptr_d;
            last_dec_q <= last_dec_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_n_q     <= we_n_d;
            pv_q       <= pv_d;
            ptag_q     <= ptag_d;
        end
    end

    assign bus.Gnt_vga         = gnt_vga;
    assign bus.Gnt_dec         = gnt_dec;
    assign bus.Gnt_uart        = gnt_uart;
    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.Rdata           = bus.SRAM_read_data;
    assign bus.Rvalid_vga      = pv_q[DEPTH-1] & (ptag_q[DEPTH-1] == TAG_VGA);
    assign bus.Rvalid_dec      = pv_q[DEPTH-1] & (ptag_q[DEPTH-1] == TAG_DEC);
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter
// Directed stimulus for sram_access_arbiter. The stimulus process drives
// requests, compares the same-cycle grant against a hand-computed value and
// queues the SRAM-port and read-return responses that grant implies. A
// separate monitor pops those queues and compares as the DUT presents them.
// A small SRAM model returns addr[15:0]^16'hC3A5 READ_LATENCY cycles after
// the address appears on the SRAM port.
module tb_sram_access_arbiter;
    localparam int RL    = 2;
    localparam int LIMIT = 8;
    localparam logic [2:0] G_0 = 3'b000;
    localparam logic [2:0] G_V = 3'b100;
    localparam logic [2:0] G_D = 3'b010;
    localparam logic [2:0] G_U = 3'b001;

    typedef struct {
        int          due;
        logic [17:0] addr;
        logic        we_n;
        logic [15:0] wdata;
        logic        has_data;
    } acc_t;

    typedef struct {
        int          due;
        logic        is_dec;
        logic [15:0] data;
    } rd_t;

    logic Clock = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   nv_wait = 0;
    logic [17:0] last_addr = '0;
    logic [15:0] last_wdata = '0;
    logic [17:0] rd_pipe [0:RL-1];
    acc_t aq[$];
    rd_t  rq[$];

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(LIMIT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // SRAM model: rd_pipe[k] holds the address of cycle (now-1-k)
    always @(posedge Clock) begin
        rd_pipe[0] <= bus.SRAM_address;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.SRAM_read_data = rd_pipe[RL-1][15:0] ^ 16'hC3A5;

    function automatic logic [15:0] mem_val(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Compare the grant for the inputs currently applied and queue its effects.
    task automatic drive_and_check(input logic [2:0] exp, input string name);
        acc_t a;
        rd_t  r;
        @(negedge Clock);
        $display("cycle %0d %s: grant vga/dec/uart=%b expected %b", cyc, name,
                 {bus.Gnt_vga, bus.Gnt_dec, bus.Gnt_uart}, exp);
        chk(name, {29'd0, bus.Gnt_vga, bus.Gnt_dec, bus.Gnt_uart}, {29'd0, exp});
        a.due = cyc + 1;
        r.due = cyc + 1 + RL;
        if (exp == G_V) begin
            a.addr = bus.Addr_vga; a.we_n = 1'b1; a.wdata = '0; a.has_data = 1'b0;
            aq.push_back(a);
            r.is_dec = 1'b0; r.data = mem_val(bus.Addr_vga);
            rq.push_back(r);
        end else if (exp == G_D) begin
            a.addr = bus.Addr_dec; a.we_n = bus.We_n_dec; a.wdata = bus.Wdata_dec; a.has_data = 1'b1;
            aq.push_back(a);
            if (bus.We_n_dec) begin
                r.is_dec = 1'b1; r.data = mem_val(bus.Addr_dec);
                rq.push_back(r);
            end
        end else if (exp == G_U) begin
            a.addr = bus.Addr_uart; a.we_n = 1'b0; a.wdata = bus.Wdata_uart; a.has_data = 1'b1;
            aq.push_back(a);
        end
        @(posedge Clock);
        #2;
    endtask

    task automatic idle(input int n);
        bus.Req_vga = 0; bus.Req_dec = 0; bus.Req_uart = 0; bus.Lock_dec = 0;
        repeat (n) drive_and_check(G_0, "idle");
    endtask

    // Assert reset for one cycle, checking every output while it is held.
    task automatic do_reset();
        Reset = 1'b1;
        aq.delete();
        rq.delete();
        last_addr = '0;
        last_wdata = '0;
        @(negedge Clock);
        $display("cycle %0d reset asserted", cyc);
        chk("rst_gnt", {29'd0, bus.Gnt_vga, bus.Gnt_dec, bus.Gnt_uart}, 32'd0);
        chk("rst_we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
        chk("rst_addr", {14'd0, bus.SRAM_address}, 32'd0);
        chk("rst_wdata", {16'd0, bus.SRAM_write_data}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.Rvalid_vga, bus.Rvalid_dec}, 32'd0);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
    endtask

    // Monitor: SRAM port, read returns and grant legality, every cycle.
    initial begin
        acc_t a;
        rd_t  r;
        forever begin
            @(negedge Clock);
            while (aq.size() > 0 && aq[0].due < cyc) begin
                a = aq.pop_front();
                chk("sram_access_missed", a.due, cyc);
            end
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front();
                chk("sram_addr", {14'd0, bus.SRAM_address}, {14'd0, a.addr});
                chk("sram_we_n", {31'd0, bus.SRAM_we_n}, {31'd0, a.we_n});
                if (!a.we_n) chk("sram_wdata", {16'd0, bus.SRAM_write_data}, {16'd0, a.wdata});
                last_addr = a.addr;
                if (a.has_data) last_wdata = a.wdata;
            end else begin
                chk("we_n_idle", {31'd0, bus.SRAM_we_n}, 32'd1);
                chk("addr_hold", {14'd0, bus.SRAM_address}, {14'd0, last_addr});
                chk("wdata_hold", {16'd0, bus.SRAM_write_data}, {16'd0, last_wdata});
            end

            while (rq.size() > 0 && rq[0].due < cyc) begin
                r = rq.pop_front();
                chk("rvalid_missed", r.due, cyc);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                chk("rvalid_tag", {30'd0, bus.Rvalid_vga, bus.Rvalid_dec},
                    r.is_dec ? 32'd1 : 32'd2);
                chk("rdata", {16'd0, bus.Rdata}, {16'd0, r.data});
            end else if (bus.Rvalid_vga || bus.Rvalid_dec) begin
                chk("rvalid_spurious", {30'd0, bus.Rvalid_vga, bus.Rvalid_dec}, 32'd0);
            end

            chk("gnt_legal",
                {31'd0, ($countones({bus.Gnt_vga, bus.Gnt_dec, bus.Gnt_uart}) <= 1) &&
                        ((bus.Gnt_vga & ~bus.Req_vga) == 1'b0) &&
                        ((bus.Gnt_dec & ~bus.Req_dec) == 1'b0) &&
                        ((bus.Gnt_uart & ~bus.Req_uart) == 1'b0)}, 32'd1);
            if (Reset || !(bus.Req_dec || bus.Req_uart) || bus.Gnt_dec || bus.Gnt_uart)
                nv_wait = 0;
            else
                nv_wait++;
            if (bus.Req_dec || bus.Req_uart)
                chk("nv_wait_bound", {31'd0, nv_wait <= LIMIT + 2}, 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        Reset = 1'b1;
        bus.Req_vga = 0; bus.Addr_vga = '0;
        bus.Req_dec = 0; bus.We_n_dec = 1; bus.Addr_dec = '0; bus.Wdata_dec = '0; bus.Lock_dec = 0;
        bus.Req_uart = 0; bus.Addr_uart = '0; bus.Wdata_uart = '0;
        @(posedge Clock);
        #2;
        bus.Req_vga = 1;
        do_reset();

        // VGA stream, addresses 0..3
        for (int i = 0; i < 4; i++) begin
            bus.Req_vga = 1; bus.Addr_vga = 18'(i);
            drive_and_check(G_V, "vga_stream");
        end
        bus.Req_vga = 0;

        // dec reads and uart writes alternate, starting with dec
        for (int i = 0; i < 4; i++) begin
            bus.Req_dec = 1; bus.We_n_dec = 1; bus.Addr_dec = 18'h00100 + 18'(i);
            bus.Req_uart = 1; bus.Addr_uart = 18'h00200 + 18'(i); bus.Wdata_uart = 16'h1230 + 16'(i);
            drive_and_check((i % 2 == 0) ? G_D : G_U, "dec_uart_rr");
        end
        idle(RL + 2);

        // Starvation: 8 VGA wins, then UART in the 9th cycle
        do_reset();
        bus.Req_uart = 1; bus.Addr_uart = 18'h00010; bus.Wdata_uart = 16'hBEEF;
        for (int i = 0; i < 9; i++) begin
            bus.Req_vga = 1; bus.Addr_vga = 18'h00300 + 18'(i);
            drive_and_check((i < 8) ? G_V : G_U, "starve");
        end
        bus.Req_uart = 0;
        bus.Addr_vga = 18'h00309;
        drive_and_check(G_V, "vga_after_starve");
        bus.Req_vga = 0;

        // Decompressor lock burst
        bus.Req_dec = 1; bus.We_n_dec = 1; bus.Addr_dec = 18'h00400; bus.Lock_dec = 1;
        drive_and_check(G_D, "lock_first");
        bus.Req_uart = 1; bus.Addr_uart = 18'h00020; bus.Wdata_uart = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            bus.We_n_dec = 0; bus.Addr_dec = 18'h00410 + 18'(i); bus.Wdata_dec = 16'hD000 + 16'(i);
            drive_and_check(G_D, "lock_hold");
        end
        bus.Req_vga = 1; bus.Addr_vga = 18'h00500;
        drive_and_check(G_V, "lock_vs_vga");
        bus.Req_vga = 0;
        bus.Addr_dec = 18'h00413; bus.Wdata_dec = 16'hD003;
        drive_and_check(G_D, "lock_resume");
        bus.Lock_dec = 0;
        drive_and_check(G_U, "unlock_uart");
        bus.Req_uart = 0;
        bus.We_n_dec = 1; bus.Addr_dec = 18'h00420;
        drive_and_check(G_D, "unlock_dec");
        idle(RL + 2);

        // Reset one cycle after a dec read grant discards it
        bus.Req_dec = 1; bus.We_n_dec = 1; bus.Addr_dec = 18'h00600;
        drive_and_check(G_D, "pre_reset_read");
        bus.We_n_dec = 0; bus.Addr_dec = 18'h00610; bus.Wdata_dec = 16'hABCD;
        do_reset();
        drive_and_check(G_D, "first_after_reset");
        bus.Req_dec = 0;
        @(negedge Clock);
        chk("rvalid_flushed", {31'd0, bus.Rvalid_dec}, 32'd0);
        @(posedge Clock);
        #2;
        idle(RL + 2);

        // All three requesting for 100 cycles
        do_reset();
        for (int i = 0; i < 100; i++) begin
            bus.Req_vga = 1; bus.Addr_vga = 18'h01000 + 18'(i);
            bus.Req_dec = 1; bus.We_n_dec = 1; bus.Addr_dec = 18'h02000 + 18'(i);
            bus.Req_uart = 1; bus.Addr_uart = 18'h03000 + 18'(i); bus.Wdata_uart = 16'(i);
            drive_and_check((i % 9 == 8) ? (((i / 9) % 2 == 0) ? G_D : G_U) : G_V, "all_three");
        end
        idle(RL + 3);

        chk("accq_drained", aq.size(), 32'd0);
        chk("readq_drained", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sram_access_arbiter.md
SRAM_ACCESS_ARBITER -- requirements
Module: sram_access_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: cycles from registered SRAM address to valid SRAM_read_data.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive VGA-won cycles a waiting non-VGA requester tolerates.
REQ-003 SHALL have port Clock, input, 1: the single clock, 50 MHz; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Req_vga, input, 1: VGA read request; held until granted.
REQ-006 SHALL have port Addr_vga, input, 18: VGA read address.
REQ-007 SHALL have port Req_dec, input, 1: decompressor access request; held until granted.
REQ-008 SHALL have port We_n_dec, input, 1: decompressor access type, 0 = write, 1 = read.
REQ-009 SHALL have port Addr_dec, input, 18: decompressor address.
REQ-010 SHALL have port Wdata_dec, input, 16: decompressor write data.
REQ-011 SHALL have port Lock_dec, input, 1: decompressor burst lock.
REQ-012 SHALL have port Req_uart, input, 1: UART write request; always a write.
REQ-013 SHALL have port Addr_uart, input, 18: UART write address.
REQ-014 SHALL have port Wdata_uart, input, 16: UART write data.
REQ-015 SHALL have ports Gnt_vga, Gnt_dec, Gnt_uart, each output, 1: combinational same-cycle grants, at most one high per cycle.
REQ-016 SHALL have port SRAM_address, output, 18, registered: address to SRAM_Controller.
REQ-017 SHALL have port SRAM_write_data, output, 16, registered: write data to SRAM_Controller.
REQ-018 SHALL have port SRAM_we_n, output, 1, registered: write enable to SRAM_Controller, active low.
REQ-019 SHALL have port SRAM_read_data, input, 16: read data from SRAM_Controller.
REQ-020 SHALL have port Rdata, output, 16: SRAM_read_data passed through.
REQ-021 SHALL have ports Rvalid_vga, Rvalid_dec, each output, 1: Rdata valid for that requester.

Function
REQ-022 SHALL perform at most one SRAM access per cycle; a grant in cycle t SHALL register that requester's address, data and we_n onto the SRAM port at edge t+1.
REQ-023 SHALL drive SRAM_we_n=1 in every cycle after a no-grant or read cycle, and SRAM_we_n=0 only for granted UART access or granted decompressor access with We_n_dec=0.
REQ-024 SHALL hold SRAM_address and SRAM_write_data at their last values when no grant occurs.
REQ-025 SHALL give VGA priority: Req_vga SHALL win every cycle unless starvation override (REQ-027) is active.
REQ-026 SHALL maintain a starvation counter: it increments (saturating at STARVE_LIMIT) each cycle VGA is granted while Req_dec or Req_uart is high; it clears on any dec/uart grant and when both are low.
REQ-027 SHALL, when the counter equals STARVE_LIMIT, deny VGA for exactly one cycle and grant the waiting non-VGA requester chosen by REQ-028/029.
REQ-028 SHALL arbitrate between dec and UART round-robin: a one-bit pointer names the preferred one, reset value dec; after each dec or uart grant the pointer names the other.
REQ-029 SHALL, when Lock_dec=1 and Req_dec=1 and the last non-VGA grant went to dec, grant dec over UART regardless of the pointer; the lock SHALL NOT override VGA priority.
REQ-030 SHALL track each granted read in a READ_LATENCY+1 deep shift register tagged with requester ID; Rvalid_x SHALL assert exactly in cycle t+1+READ_LATENCY for a read granted in cycle t (default t+3).
REQ-031 SHALL support back-to-back reads every cycle with no bubbles, delivering Rvalid in grant order.
REQ-032 SHALL NOT generate Rvalid for writes.
REQ-033 SHALL NOT drop grant requests: an ungranted requester is served later with its then-current address and data.

Reset
REQ-034 SHALL, while Reset=1, asynchronously force the following: grants 0, SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0, Rvalid_vga 0, Rvalid_dec 0, starvation counter 0, pointer to dec, lock history cleared.
REQ-035 SHALL discard in-flight reads on reset with no Rvalid afterwards, and SHALL grant normally from the first edge after Reset falls.

Verification
REQ-036 SHALL be checked with: Req_vga only, addresses 0..3 consecutive -> Gnt_vga every cycle; SRAM_address 0..3 one cycle later; Rvalid_vga at t+3..t+6.
REQ-037 SHALL be checked with: Req_dec read and Req_uart write both held, Req_vga=0 -> grants alternate dec, uart, dec...; SRAM_we_n toggles 1,0,1; Rvalid_dec only 3 cycles after each dec grant.
REQ-038 SHALL be checked with: Req_vga held with Req_uart=1 (Addr 18'h00010, Wdata 16'hBEEF) -> 8 VGA grants, then Gnt_uart in the 9th cycle, and SRAM write of 16'hBEEF to 18'h00010 on the next edge.
REQ-039 SHALL be checked with: Lock_dec=1 and Req_dec held with Req_uart=1 after a dec grant -> dec granted every cycle; UART is granted only after Lock_dec falls.
REQ-040 SHALL be checked with: Reset pulsed one cycle after a dec read grant -> no Rvalid_dec; all outputs at REQ-034 values; first grant on the edge after Reset falls.
REQ-041 SHALL be checked with: all three requesting every cycle for 100 cycles -> at most one grant per cycle, no Gnt_x without Req_x, and no non-VGA requester waiting more than STARVE_LIMIT+2 cycles.
